opto_pulse_sequencer: RTL

OPTO_PULSE_SEQUENCER -- requirements
Module: opto_pulse_sequencer

---
 rtl/opto_seq_pkg.sv | 34 +++
 rtl/opto_seq_timer.sv | 27 ++
 rtl/opto_pulse_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/opto_seq_pkg.sv
// Shared types and constants for the opto pulse sequencer: state encoding,
// register map and command/status bit positions.
package opto_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StGap
  } seq_state_e;

  localparam logic [1:0] REG_CMD   = 2'd0;
  localparam logic [1:0] REG_WIDTH = 2'd1;
  localparam logic [1:0] REG_GAP   = 2'd2;
  localparam logic [1:0] REG_STAT  = 2'd3;

  localparam int unsigned CMD_START_BIT = 4;
  localparam int unsigned CMD_ABORT_BIT = 5;
  localparam int unsigned STAT_CLR_BIT  = 0;
  localparam int unsigned STAT_BUSY_BIT = 2;
  localparam int unsigned STAT_DONE_BIT = 3;

  // Lowest set channel; callers only use the result when the mask is non-zero.
  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    if (m[0]) return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else return 2'd3;
  endfunction

  function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/opto_seq_timer.sv
// Loadable down-counter shared by the PULSE and GAP phases; it stops at zero.
module opto_seq_timer #(
  parameter int unsigned TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               en,
  input  logic [TIMER_W-1:0] load_value,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (en && !zero) begin
      count_q <= count_q - TIMER_W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/opto_pulse_sequencer.sv
// Avalon-controlled sequencer that fires one opto channel at a time, in ascending
// channel order, with programmable pulse width and inter-pulse gap.
module opto_pulse_sequencer #(
  parameter int unsigned TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [TIMER_W-1:0] writedata,
  output logic [TIMER_W-1:0] readdata,
  output logic [3:0]         out_port,
  output logic               irq
);

  import opto_seq_pkg::*;

  seq_state_e         state_q, state_d;
  logic [3:0]         mask_q;
  logic [3:0]         work_mask_q, work_mask_d;
  logic [3:0]         out_q, out_d;
  logic [TIMER_W-1:0] width_q, gap_q;
  logic [TIMER_W-1:0] work_width_q, work_width_d;
  logic [TIMER_W-1:0] work_gap_q, work_gap_d;
  logic [TIMER_W-1:0] width_m1, timer_value;
  logic [1:0]         cur_ch_q, cur_ch_d;
  logic [1:0]         start_ch, next_ch;
  logic               done_q, done_d;
  logic               timer_load, timer_en, timer_zero;
  logic               wr, cmd_wr, start, abort, busy;

  assign wr     = chipselect && !write_n;
  assign cmd_wr = wr && (address == REG_CMD);
  assign start  = cmd_wr && writedata[CMD_START_BIT];
  assign abort  = cmd_wr && writedata[CMD_ABORT_BIT];
  assign busy   = (state_q != StIdle);

  // Timer holds cycles-remaining-minus-one, so width 0 and width 1 both give one cycle.
  assign width_m1 = (width_q == '0) ? '0 : width_q - TIMER_W'(1);
  assign start_ch = lowest_ch(writedata[3:0]);
  assign next_ch  = lowest_ch(work_mask_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q  <= '0;
      width_q <= TIMER_W'(1);
      gap_q   <= '0;
    end else if (wr) begin
      case (address)
        REG_CMD:   if (!busy) mask_q <= writedata[3:0];
        REG_WIDTH: width_q <= writedata;
        REG_GAP:   gap_q <= writedata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    work_mask_d  = work_mask_q;
    work_width_d = work_width_q;
    work_gap_d   = work_gap_q;
    cur_ch_d     = cur_ch_q;
    done_d       = done_q;
    timer_load   = 1'b0;
    timer_en     = 1'b0;
    timer_value  = '0;

    // Clear first so any set below takes priority in the same cycle.
    if (wr && (address == REG_STAT) && writedata[STAT_CLR_BIT]) begin
      done_d = 1'b0;
    end

    if (abort) begin
      state_d = StIdle;
      out_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            if (writedata[3:0] == 4'd0) begin
              done_d = 1'b1;
            end else begin
              state_d      = StPulse;
              cur_ch_d     = start_ch;
              out_d        = ch_onehot(start_ch);
              work_mask_d  = writedata[3:0] & ~ch_onehot(start_ch);
              work_width_d = width_m1;
              work_gap_d   = gap_q;
              timer_load   = 1'b1;
              timer_value  = width_m1;
            end
          end
        end
        StPulse: begin
          if (!timer_zero) begin
            timer_en = 1'b1;
          end else if (work_mask_q == 4'd0) begin
            state_d = StIdle;
            out_d   = '0;
            done_d  = 1'b1;
          end else if (work_gap_q == '0) begin
            state_d     = StPulse;
            cur_ch_d    = next_ch;
            out_d       = ch_onehot(next_ch);
            work_mask_d = work_mask_q & ~ch_onehot(next_ch);
            timer_load  = 1'b1;
            timer_value = work_width_q;
          end else begin
            state_d     = StGap;
            out_d       = '0;
            timer_load  = 1'b1;
            timer_value = work_gap_q - TIMER_W'(1);
          end
        end
        StGap: begin
          if (!timer_zero) begin
            timer_en = 1'b1;
          end else begin
            state_d     = StPulse;
            cur_ch_d    = next_ch;
            out_d       = ch_onehot(next_ch);
            work_mask_d = work_mask_q & ~ch_onehot(next_ch);
            timer_load  = 1'b1;
            timer_value = work_width_q;
          end
        end
        default: begin
          state_d = StIdle;
          out_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      out_q        <= '0;
      work_mask_q  <= '0;
      work_width_q <= '0;
      work_gap_q   <= '0;
      cur_ch_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      work_mask_q  <= work_mask_d;
      work_width_q <= work_width_d;
      work_gap_q   <= work_gap_d;
      cur_ch_q     <= cur_ch_d;
      done_q       <= done_d;
    end
  end

  opto_seq_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .en         (timer_en),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_comb begin
    readdata = '0;
    case (address)
      REG_CMD:   readdata[3:0] = mask_q;
      REG_WIDTH: readdata = width_q;
      REG_GAP:   readdata = gap_q;
      REG_STAT: begin
        readdata[1:0]          = cur_ch_q;
        readdata[STAT_BUSY_BIT] = busy;
        readdata[STAT_DONE_BIT] = done_q;
      end
      default: ;
    endcase
  end

  assign out_port = out_q;
  assign irq      = done_q;

endmodule
